// File: rtl/shmem_copy_master.sv
// shmem_copy_master
// Copies cmd_len words from cmd_src to cmd_dst through one shared-memory
// arbiter port. Each word is one read access followed by one write access.
// Every access is followed by a single idle cycle on the port. Addresses
// wrap modulo 2^ADDR_WIDTH. Overlapping ranges are copied in ascending order.
module shmem_copy_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_src,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  busy,
    output logic                  xfer_done,
    output logic [LEN_WIDTH-1:0]  word_cnt,
    output logic                  shmem_request,
    output logic                  shmem_wren,
    output logic [ADDR_WIDTH-1:0] shmem_addr,
    output logic [DATA_WIDTH-1:0] shmem_datain,
    input  logic [DATA_WIDTH-1:0] shmem_dataout,
    input  logic                  shmem_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_REQ = 3'd1;
    localparam logic [2:0] S_RD_GAP = 3'd2;
    localparam logic [2:0] S_WR_REQ = 3'd3;
    localparam logic [2:0] S_WR_GAP = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] cnt_offset;

    assign cmd_ready  = (state == S_IDLE);
    // Word offset folded to the address width. Truncation gives the modulo wrap.
    assign cnt_offset = ADDR_WIDTH'(word_cnt);

    // Sequencer: command acceptance, read/write handshakes, registered port outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            // The reset clears every register, including the data and command
            // holding registers, so an aborted copy leaves nothing stale behind.
            state         <= S_IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            data_q        <= '0;
            busy          <= 1'b0;
            xfer_done     <= 1'b0;
            word_cnt      <= '0;
            shmem_request <= 1'b0;
            shmem_wren    <= 1'b0;
            shmem_addr    <= '0;
            shmem_datain  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every branch read the pre-edge
            // word_cnt and state, so the port outputs and counter move together.
            xfer_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy covers the done-pulse cycle and clears after it,
                    // unless a new command is accepted in that same cycle.
                    busy <= cmd_valid;
                    if (cmd_valid) begin
                        src_q    <= cmd_src;
                        dst_q    <= cmd_dst;
                        len_q    <= cmd_len;
                        word_cnt <= '0;
                        if (cmd_len == '0) begin
                            state <= S_FIN;
                        end else begin
                            state         <= S_RD_REQ;
                            shmem_request <= 1'b1;
                            shmem_wren    <= 1'b0;
                            shmem_addr    <= cmd_src;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (shmem_done) begin
                        data_q        <= shmem_dataout;
                        shmem_request <= 1'b0;
                        state         <= S_RD_GAP;
                    end
                end
                S_RD_GAP: begin
                    state         <= S_WR_REQ;
                    shmem_request <= 1'b1;
                    shmem_wren    <= 1'b1;
                    shmem_addr    <= dst_q + cnt_offset;
                    shmem_datain  <= data_q;
                end
                S_WR_REQ: begin
                    if (shmem_done) begin
                        word_cnt      <= word_cnt + 1'b1;
                        shmem_request <= 1'b0;
                        state         <= S_WR_GAP;
                    end
                end
                S_WR_GAP: begin
                    if (word_cnt == len_q) begin
                        state <= S_FIN;
                    end else begin
                        state         <= S_RD_REQ;
                        shmem_request <= 1'b1;
                        shmem_wren    <= 1'b0;
                        shmem_addr    <= src_q + cnt_offset;
                    end
                end
                S_FIN: begin
                    // The registered pulse appears in the cycle after FIN. That
                    // is two cycles after acceptance for a zero-length command.
                    xfer_done <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state         <= S_IDLE;
                    busy          <= 1'b0;
                    shmem_request <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shmem_copy_master.sv
// Self-checking bench for shmem_copy_master.
// A behavioural shared-memory port answers each request with a random
// arbitration delay. Every copy is predicted word by word from the source,
// destination and length.
module tb_shmem_copy_master;

    localparam int AW        = 12;
    localparam int DW        = 32;
    localparam int LW        = 12;
    localparam int MEM_WORDS = 1 << AW;

    typedef struct {
        logic          wren;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    logic          clk = 1'b0;
    logic          srst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [LW-1:0] cmd_len;
    logic          busy;
    logic          xfer_done;
    logic [LW-1:0] word_cnt;
    logic          shmem_request;
    logic          shmem_wren;
    logic [AW-1:0] shmem_addr;
    logic [DW-1:0] shmem_datain;
    logic [DW-1:0] shmem_dataout;
    logic          shmem_done;

    always #5 clk = ~clk;

    shmem_copy_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_src      (cmd_src),
        .cmd_dst      (cmd_dst),
        .cmd_len      (cmd_len),
        .busy         (busy),
        .xfer_done    (xfer_done),
        .word_cnt     (word_cnt),
        .shmem_request(shmem_request),
        .shmem_wren   (shmem_wren),
        .shmem_addr   (shmem_addr),
        .shmem_datain (shmem_datain),
        .shmem_dataout(shmem_dataout),
        .shmem_done   (shmem_done)
    );

    logic [DW-1:0] mem  [MEM_WORDS];
    logic [DW-1:0] gold [MEM_WORDS];
    acc_t          exp_q[$];
    int            total     = 0;
    int            bad       = 0;
    int            req_count = 0;
    int            lat_lo    = 0;
    int            lat_hi    = 0;
    bit            spurious  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Predict the copy: ascending word order, addresses wrap, overlap is honoured.
    task automatic plan(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len);
        for (int i = 0; i < MEM_WORDS; i++) gold[i] = mem[i];
        exp_q.delete();
        for (int k = 0; k < len; k++) begin
            logic [AW-1:0] ra;
            logic [AW-1:0] wa;
            ra = src + AW'(k);
            wa = dst + AW'(k);
            exp_q.push_back('{wren: 1'b0, addr: ra, data: '0});
            exp_q.push_back('{wren: 1'b1, addr: wa, data: gold[ra]});
            gold[wa] = gold[ra];
        end
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== gold[i]) n++;
        return n;
    endfunction

    // Shared-memory port model: random grant delay, hold and idle-gap checks,
    // and stray done pulses while no request is pending.
    bit   rsp_pending;
    bit   rsp_post;
    bit   rsp_follow;
    int   rsp_wait;
    acc_t rsp_cur;
    acc_t rsp_exp;

    initial begin : responder
        rsp_pending   = 1'b0;
        rsp_post      = 1'b0;
        rsp_follow    = 1'b0;
        rsp_wait      = 0;
        shmem_done    = 1'b0;
        shmem_dataout = '0;
        forever begin
            @(negedge clk);
            shmem_done = 1'b0;
            if (srst) begin
                rsp_pending = 1'b0;
                rsp_post    = 1'b0;
                rsp_follow  = 1'b0;
                exp_q.delete();
            end else begin
                if (rsp_follow) begin
                    rsp_follow = 1'b0;
                    check("one_idle_cycle", shmem_request, 1);
                end
                if (rsp_post) begin
                    rsp_post = 1'b0;
                    check("idle_after_done", shmem_request, 0);
                    rsp_follow = (exp_q.size() != 0);
                end
                if (rsp_pending) begin
                    check("hold_request", shmem_request, 1);
                    check("hold_wren", shmem_wren, rsp_cur.wren);
                    check("hold_addr", shmem_addr, rsp_cur.addr);
                    if (rsp_cur.wren) check("hold_datain", shmem_datain, rsp_cur.data);
                end else if (shmem_request) begin
                    req_count++;
                    rsp_cur = '{wren: shmem_wren, addr: shmem_addr, data: shmem_datain};
                    if (exp_q.size() == 0) begin
                        check("unexpected_access", 1, 0);
                    end else begin
                        rsp_exp = exp_q.pop_front();
                        check("access_wren", shmem_wren, rsp_exp.wren);
                        check("access_addr", shmem_addr, rsp_exp.addr);
                        if (rsp_exp.wren) check("access_datain", shmem_datain, rsp_exp.data);
                    end
                    rsp_pending = 1'b1;
                    rsp_wait    = $urandom_range(lat_hi, lat_lo);
                end else if (spurious && $urandom_range(3, 0) == 0) begin
                    shmem_done    = 1'b1;
                    shmem_dataout = $urandom;
                end
                if (rsp_pending) begin
                    if (rsp_wait == 0) begin
                        shmem_done = 1'b1;
                        if (rsp_cur.wren) mem[rsp_cur.addr] = rsp_cur.data;
                        else shmem_dataout = mem[rsp_cur.addr];
                        rsp_pending = 1'b0;
                        rsp_post    = 1'b1;
                    end else begin
                        rsp_wait--;
                    end
                end
            end
        end
    end

    // Issue one command, then watch busy and xfer_done until two cycles after the pulse.
    task automatic run_cmd(input string name, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input int len, input bit poke);
        int cyc, first, dones, busy_bad, budget, req0;
        plan(src, dst, len);
        req0   = req_count;
        budget = len * (2 * lat_hi + 10) + 10;
        check({name, "_ready"}, cmd_ready, 1);
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({name, "_ready_low"}, cmd_ready, 0);
        cyc = 1; first = 0; dones = 0; busy_bad = 0;
        forever begin
            if (xfer_done) begin
                dones++;
                if (first == 0) first = cyc;
            end
            if (first == 0 || cyc == first) begin
                if (busy !== 1'b1) busy_bad++;
            end else if (busy !== 1'b0) begin
                busy_bad++;
            end
            if (poke && cyc >= 2 && cyc <= 4) begin
                check({name, "_ready_while_busy"}, cmd_ready, 0);
                cmd_valid = 1'b1;
                cmd_src   = AW'($urandom);
                cmd_dst   = AW'($urandom);
                cmd_len   = LW'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            if ((first != 0 && cyc >= first + 2) || cyc >= budget) break;
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        check({name, "_done_seen"}, first != 0, 1);
        check({name, "_done_count"}, dones, 1);
        check({name, "_busy_window"}, busy_bad, 0);
        check({name, "_word_cnt"}, word_cnt, len);
        check({name, "_accesses"}, req_count - req0, 2 * len);
        check({name, "_mem"}, mem_diffs(), 0);
        if (len == 0) check({name, "_zero_latency"}, first, 2);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin : main
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        int            len;
        int            extra_done;

        srst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_xfer_done", xfer_done, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_request", shmem_request, 0);
        check("rst_wren", shmem_wren, 0);
        check("rst_addr", shmem_addr, 0);
        check("rst_datain", shmem_datain, 0);
        srst = 1'b0;
        @(negedge clk);
        check("ready_after_release", cmd_ready, 1);

        // Single word, grant one cycle after each request.
        lat_lo = 1; lat_hi = 1; spurious = 1'b0;
        mem[12'h010] = 32'hDEADBEEF;
        run_cmd("single", 12'h010, 12'h200, 1, 1'b0);
        check("single_value", mem[12'h200], 32'hDEADBEEF);

        // Zero length, with stray done pulses on the idle port.
        lat_lo = 0; lat_hi = 2; spurious = 1'b1;
        run_cmd("zero", AW'($urandom), AW'($urandom), 0, 1'b0);

        // Address wrap on the source side.
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = DW'(i);
        run_cmd("wrap", 12'hFFE, 12'h7FE, 4, 1'b0);
        check("wrap_7fe", mem[12'h7FE], 32'h0000_0FFE);
        check("wrap_7ff", mem[12'h7FF], 32'h0000_0FFF);
        check("wrap_800", mem[12'h800], 32'h0000_0000);
        check("wrap_801", mem[12'h801], 32'h0000_0001);

        // Long arbitration stalls.
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        lat_lo = 2; lat_hi = 9;
        run_cmd("stall", AW'($urandom), AW'($urandom), 64, 1'b0);

        // A second command presented mid-transfer must be ignored.
        lat_lo = 0; lat_hi = 3;
        run_cmd("busy_cmd", AW'($urandom), AW'($urandom), 8, 1'b1);

        // Reset after five words of a sixteen-word copy.
        src = AW'($urandom);
        dst = src + 12'h400;
        plan(src, dst, 16);
        cmd_src = src; cmd_dst = dst; cmd_len = LW'(16); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 400 && word_cnt != LW'(5); c++) @(negedge clk);
        check("abort_reached_5", word_cnt, 5);
        srst = 1'b1;
        @(negedge clk);
        check("abort_request", shmem_request, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_xfer_done", xfer_done, 0);
        @(negedge clk);
        srst = 1'b0;
        extra_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (xfer_done) extra_done++;
        end
        check("abort_no_done", extra_done, 0);
        run_cmd("after_abort", AW'($urandom), AW'($urandom), 2, 1'b0);

        // Random copies, including overlapping ranges in both directions.
        for (int t = 0; t < 9; t++) begin
            src = AW'($urandom);
            case (t % 3)
                0:       dst = AW'($urandom);
                1:       dst = src + AW'($urandom_range(3, 1));
                default: dst = src - AW'($urandom_range(3, 1));
            endcase
            len = $urandom_range(40, 0);
            run_cmd("rand", src, dst, len, 1'b0);
        end

        // Largest legal length.
        lat_lo = 0; lat_hi = 0; spurious = 1'b0;
        run_cmd("max_len", AW'($urandom), AW'($urandom), (1 << LW) - 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shmem_copy_master.md
SHMEM_COPY_MASTER -- requirements
Module: shmem_copy_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: word-address width of the shared-memory port.
REQ-002 Parameter DATA_WIDTH, default 32: data word width.
REQ-003 Parameter LEN_WIDTH, default 12: width of the transfer length in words.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 srst  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  block idle, command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_src  input  ADDR_WIDTH  source start word address.
REQ-009 cmd_dst  input  ADDR_WIDTH  destination start word address.
REQ-010 cmd_len  input  LEN_WIDTH  number of words to copy.
REQ-011 busy  output  1  high from the cycle after acceptance until the done pulse, inclusive.
REQ-012 xfer_done  output  1  one-cycle pulse when a command completes.
REQ-013 word_cnt  output  LEN_WIDTH  words fully written in the current or last command.
REQ-014 shmem_request  output  1  access request to one shared-memory arbiter port.
REQ-015 shmem_wren  output  1  1 = write, 0 = read; valid while shmem_request is high.
REQ-016 shmem_addr  output  ADDR_WIDTH  access address.
REQ-017 shmem_datain  output  DATA_WIDTH  write data.
REQ-018 shmem_dataout  input  DATA_WIDTH  read data, valid in the cycle shmem_done is high.
REQ-019 shmem_done  input  1  one-cycle grant/completion pulse for the pending access.

Function
REQ-020 FSM states: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FIN; cmd_ready = (state == IDLE).
REQ-021 IDLE: on cmd_valid, latch src, dst and len, clear word_cnt, and go to FIN if len == 0, else RD_REQ.
REQ-022 RD_REQ: shmem_request=1, wren=0, addr=src+word_cnt; on shmem_done, capture shmem_dataout into the data register and go to RD_GAP.
REQ-023 RD_GAP: shmem_request=0 for exactly one cycle, then go to WR_REQ.
REQ-024 WR_REQ: shmem_request=1, wren=1, addr=dst+word_cnt, datain = captured word; on shmem_done, increment word_cnt and go to WR_GAP.
REQ-025 WR_GAP: shmem_request=0 for one cycle; go to FIN if word_cnt == len, else RD_REQ.
REQ-026 FIN: xfer_done=1 for one cycle, then go to IDLE; busy=1 in FIN.
REQ-027 While request is high, addr, wren and datain are held stable until shmem_done is sampled; shmem_done outside RD_REQ/WR_REQ is ignored.
REQ-028 Address arithmetic is modulo 2^ADDR_WIDTH: src/dst + word_cnt wraps silently.
REQ-029 cmd_len = 2^LEN_WIDTH-1 is legal; word_cnt never overflows within a command.
REQ-030 Overlapping src/dst ranges are copied in ascending order word by word, with no hazard protection.
REQ-031 cmd_valid while busy is ignored and is not queued.
REQ-032 All outputs are registered; each word costs at least 4 cycles plus arbitration wait.
REQ-033 word_cnt holds its final value in IDLE until the next accepted command.

Reset
REQ-034 srst forces IDLE, shmem_request=0, shmem_wren=0, shmem_addr=0, shmem_datain=0, xfer_done=0, word_cnt=0, and internal registers to 0; cmd_ready=1 in the first cycle after release.
REQ-035 srst mid-transfer aborts immediately; no xfer_done is issued and a pending access is dropped.

Verification
REQ-036 Single word: mem[0x010]=0xDEADBEEF, cmd src=0x010 dst=0x200 len=1, done returned 1 cycle after each request -> mem[0x200]=0xDEADBEEF, one xfer_done, word_cnt=1, 2 requests total.
REQ-037 Zero length: cmd len=0 -> xfer_done 2 cycles after acceptance, shmem_request never asserted, word_cnt=0.
REQ-038 Wrap: src=0xFFE dst=0x7FE len=4, mem[i]=i -> dst 0x7FE..0x801 hold the values from 0xFFE, 0xFFF, 0x000, 0x001.
REQ-039 Arbitration stall: this block sits on port 3 of a 4-port shmemif with other ports saturated, len=64 -> all 64 words correct, request and address stable while waiting, one idle cycle after every done.
REQ-040 Reset mid-operation: srst asserted after word_cnt=5 of len=16 -> next cycle request=0 and cmd_ready=1, no xfer_done, and a new command len=2 completes correctly.
REQ-041 Busy command: second cmd_valid asserted during a transfer -> ignored, cmd_ready=0, and only one xfer_done is issued.
